// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset controller: opcode and
// function-field constants, datapath select encodings, ALU decoder modes and
// the sequencer state enum.
package riscv_mc_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNC3_W  = 3;
    localparam int unsigned FUNC7_W  = 7;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned IMMSRC_W = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned FSM_W    = 4;

    // Opcodes (IR[6:0])
    localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B    = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI  = 7'b0110111;

    // func3 / func7 values used by the decoders
    localparam logic [FUNC3_W-1:0] F3_ADD = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_SLT = 3'b010;
    localparam logic [FUNC3_W-1:0] F3_XOR = 3'b100;
    localparam logic [FUNC3_W-1:0] F3_OR  = 3'b110;
    localparam logic [FUNC3_W-1:0] F3_AND = 3'b111;
    localparam logic [FUNC3_W-1:0] F3_BEQ = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_BNE = 3'b001;
    localparam logic [FUNC7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [FUNC7_W-1:0] F7_ALT  = 7'b0100000;

    // ALUControl
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b100;
    localparam logic [ALUCTL_W-1:0] ALU_XOR = 3'b110;

    // ImmSrc
    localparam logic [IMMSRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMMSRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMMSRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMMSRC_W-1:0] IMM_J = 3'b011;
    localparam logic [IMMSRC_W-1:0] IMM_U = 3'b100;

    // ResultSrc
    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;
    localparam logic [SEL_W-1:0] RES_IMM    = 2'b11;

    // ALUSrcA / ALUSrcB
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_REG   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    // ALU decoder modes
    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_R   = 2'd2,
        MODE_I   = 2'd3
    } alu_mode_t;

    // Sequencer states; encodings are visible on StateO
    typedef enum logic [FSM_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_PC  = 4'd12,
        S_LUI      = 4'd13,
        S_ERROR    = 4'd14
    } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle.
//   master: controller side (IR fields, Zero, MemReady in; selects/enables out)
//   slave : datapath side (mirror image)
// With MULTICYCLE_ILLEGAL_TRAP_EN defined the bundle also carries Illegal.
interface multicycle_controller_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic               Zero;
    logic               MemReady;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUControl;
    logic [2:0]         ImmSrc;
    logic [STATE_W-1:0] StateO;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic               Illegal;
`endif

    modport master (
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        output Illegal,
`endif
        input  op, func3, func7, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, StateO
    );

    modport slave (
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        input  Illegal,
`endif
        output op, func3, func7, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, StateO
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decoder.
//   mode        : forced add, forced sub, R-type decode or I-type decode
//   func3/func7 : instruction function fields from the IR
//   alu_control : ALU operation select; unsupported combinations give add
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_mode_t              mode,
    input  logic [FUNC3_W-1:0]     func3,
    input  logic [FUNC7_W-1:0]     func7,
    output logic [ALUCTL_W-1:0]    alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (mode)
            MODE_SUB: alu_control = ALU_SUB;
            MODE_R: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        F3_SLT:  alu_control = ALU_SLT;
                        F3_XOR:  alu_control = ALU_XOR;
                        F3_OR:   alu_control = ALU_OR;
                        F3_AND:  alu_control = ALU_AND;
                        default: alu_control = ALU_ADD;
                    endcase
                end else if (func7 == F7_ALT && func3 == F3_ADD) begin
                    alu_control = ALU_SUB;
                end
            end
            // andi is not part of the subset, so 3'b111 falls back to add
            MODE_I: begin
                case (func3)
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_XOR:  alu_control = ALU_XOR;
                    F3_OR:   alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset sequencer. Walks each instruction through its
// phases, sharing one ALU and one memory port, and stalls on MemReady.
//   clk, rst : clock, synchronous active-high reset
//   bus      : multicycle_controller_if.master (IR fields, Zero, MemReady in;
//              datapath enables/selects, ALUControl, ImmSrc, StateO out)
// Optional: MULTICYCLE_ILLEGAL_TRAP_EN sends unknown opcodes and unsupported
// branch func3 to a sticky ERROR state and drives bus.Illegal.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter int unsigned STATE_W = 4
)(
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);

    state_t                 state_q;
    state_t                 state_d;
    alu_mode_t              alu_mode;
    logic [ALUCTL_W-1:0]    alu_ctrl;
    logic                   pc_write;
    logic                   mem_write;
    logic                   ir_write;
    logic                   reg_write;

    mc_alu_decoder u_alu_dec (
        .mode        (alu_mode),
        .func3       (bus.func3),
        .func7       (bus.func7),
        .alu_control (alu_ctrl)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state datapath controls
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_mode      = MODE_ADD;
        bus.AdrSrc    = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_REG;
        bus.ImmSrc    = IMM_I;

        case (state_q)
            S_FETCH: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
                ir_write      = bus.MemReady;
                pc_write      = bus.MemReady;
                if (bus.MemReady) begin
                    state_d = S_DECODE;
                end
            end
            // ALUOut captures OldPC + imm as the branch/jal target
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.op == OP_JAL) ? IMM_J : IMM_B;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      state_d = S_ERROR;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.op == OP_SW) ? IMM_S : IMM_I;
                state_d     = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (bus.MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            // Write request stays up for the whole stall
            S_MEMWRITE: begin
                bus.AdrSrc    = 1'b1;
                bus.ResultSrc = RES_ALUOUT;
                mem_write     = 1'b1;
                if (bus.MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_REG;
                alu_mode    = MODE_R;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_I;
                alu_mode    = MODE_I;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            // PC takes the DECODE-computed target from ALUOut when taken
            S_BRANCH: begin
                bus.ALUSrcA   = SRCA_REG;
                bus.ALUSrcB   = SRCB_REG;
                bus.ResultSrc = RES_ALUOUT;
                alu_mode      = MODE_SUB;
                state_d       = S_FETCH;
                case (bus.func3)
                    F3_BEQ:  pc_write = bus.Zero;
                    F3_BNE:  pc_write = ~bus.Zero;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default: state_d  = S_ERROR;
`else
                    default: pc_write = 1'b0;
`endif
                endcase
            end
            // PC <- target in ALUOut while the ALU forms the OldPC + 4 link
            S_JAL: begin
                bus.ALUSrcA   = SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALUOUT;
                pc_write      = 1'b1;
                state_d       = S_ALUWB;
            end
            S_JALR: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_I;
                state_d     = S_JALR_PC;
            end
            // rs1 was latched in DECODE, so rd == rs1 is safe here
            S_JALR_PC: begin
                bus.ALUSrcA   = SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALUOUT;
                pc_write      = 1'b1;
                state_d       = S_ALUWB;
            end
            S_LUI: begin
                bus.ImmSrc    = IMM_U;
                bus.ResultSrc = RES_IMM;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_ERROR: state_d = S_ERROR;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are forced low in any cycle where reset is seen
    always_comb begin
        bus.PCWrite    = pc_write  & ~rst;
        bus.MemWrite   = mem_write & ~rst;
        bus.IRWrite    = ir_write  & ~rst;
        bus.RegWrite   = reg_write & ~rst;
        bus.ALUControl = alu_ctrl;
        bus.StateO     = STATE_W'(state_q);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        bus.Illegal    = (state_q == S_ERROR);
`endif
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised self-checking bench for multicycle_controller. Each instruction
// is expanded into the cycle-by-cycle output trace it must produce; one
// compare process checks the DUT against that trace on every cycle.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03, OP_SW = 7'h23;
    localparam logic [6:0] OP_B = 7'h63, OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_LUI = 7'h37;
    localparam logic [6:0] OP_BAD = 7'h7f;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu, imm;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_controller_if #(.STATE_W(4)) bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t        tr[$];
    int          mr_q[$];
    int          z_q[$];
    obs_t        exp_cur;
    obs_t        act;
    bit          chk_en;
    bit          en_only;
    bit          lit_valid;
    string       lit_name;
    int          lit_got, lit_exp;
    int          n_chk, n_pass;
    int          dut_len;
    bit          left_fetch;
    string       cur_name;

    function automatic obs_t mk(input int st, pcw, adr, memw, irw, regw, res, sa, sb, alu, imm);
        obs_t o;
        o.st = 4'(st);   o.pcw = 1'(pcw);   o.adr = 1'(adr);   o.memw = 1'(memw);
        o.irw = 1'(irw); o.regw = 1'(regw); o.res = 2'(res);   o.sa = 2'(sa);
        o.sb = 2'(sb);   o.alu = 3'(alu);   o.imm = 3'(imm);
        return o;
    endfunction

    function automatic int rb();
        return int'($urandom_range(0, 1));
    endfunction

    // R-type ALU op: func7 = 0 selects from the func3 table, 0100000/000 is sub
    function automatic int r_alu(input logic [2:0] f3, input logic [6:0] f7);
        int tab [8];
        tab = '{0, 0, 4, 0, 6, 0, 3, 2};
        if (f7 == 7'h00) return tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return 1;
        return 0;
    endfunction

    function automatic int i_alu(input logic [2:0] f3);
        case (f3)
            3'd2:    return 4;
            3'd4:    return 6;
            3'd6:    return 3;
            default: return 0;
        endcase
    endfunction

    // Compare process: per-cycle trace check plus queued literal checks
    always @(negedge clk) begin
        act = {bus.StateO, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc};
        if (chk_en) begin
            n_chk++;
            if (en_only ? ({act.pcw, act.memw, act.irw, act.regw} == 4'b0) : (act === exp_cur))
                n_pass++;
            else
                $display("FAIL %s t=%0t: got %h expected %h%s", cur_name, $time, act, exp_cur,
                         en_only ? " (enables must be 0)" : "");
        end
        if (lit_valid) begin
            n_chk++;
            if (lit_got == lit_exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d", lit_name, lit_got, lit_exp);
        end
    end

    task automatic push(input obs_t o, input int mr, input int z);
        tr.push_back(o);
        mr_q.push_back(mr);
        z_q.push_back(z);
    endtask

    // `stalls` not-ready cycles followed by the ready cycle
    task automatic wait_phase(input obs_t busy, input obs_t done, input int stalls);
        for (int i = 0; i < stalls; i++) push(busy, 0, rb());
        push(done, 1, rb());
    endtask

    task automatic build(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int zero, input int fs, input int ms);
        obs_t wb;
        int   pcw;
        wb = mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tr.delete(); mr_q.delete(); z_q.delete();
        cur_name  = name;
        bus.op    = op;
        bus.func3 = f3;
        bus.func7 = f7;
        wait_phase(mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0), mk(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0), fs);
        push(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, (op == OP_JAL) ? 3 : 2), rb(), rb());
        case (op)
            OP_LW: begin
                push(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0), rb(), rb());
                wait_phase(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ms);
                push(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), rb(), rb());
            end
            OP_SW: begin
                push(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1), rb(), rb());
                wait_phase(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), ms);
            end
            OP_R: begin
                push(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, r_alu(f3, f7), 0), rb(), rb());
                push(wb, rb(), rb());
            end
            OP_I: begin
                push(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, i_alu(f3), 0), rb(), rb());
                push(wb, rb(), rb());
            end
            OP_B: begin
                pcw = (f3 == 3'd0) ? zero : (f3 == 3'd1) ? 1 - zero : 0;
                push(mk(9, pcw, 0, 0, 0, 0, 0, 2, 0, 1, 0), rb(), zero);
            end
            OP_JAL: begin
                push(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0), rb(), rb());
                push(wb, rb(), rb());
            end
            OP_JALR: begin
                push(mk(11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0), rb(), rb());
                push(mk(12, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0), rb(), rb());
                push(wb, rb(), rb());
            end
            OP_LUI: push(mk(13, 0, 0, 0, 0, 1, 3, 0, 0, 0, 4), rb(), rb());
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) push(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
`endif
            end
        endcase
    endtask

    // One clock: drive inputs, let the compare process sample, advance
    task automatic step(input obs_t e, input int mr, input int z);
        bus.MemReady = 1'(mr);
        bus.Zero     = 1'(z);
        exp_cur      = e;
        chk_en       = 1'b1;
        if (bus.StateO != 4'd0 || !left_fetch) dut_len++;
        if (bus.StateO != 4'd0) left_fetch = 1'b1;
        @(posedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        en_only = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
        en_only = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic exec(input int abort);
        dut_len    = 0;
        left_fetch = 1'b0;
        for (int i = 0; i < tr.size(); i++) begin
            if (i == abort) begin
                do_reset();
                return;
            end
            step(tr[i], mr_q[i], z_q[i]);
        end
    endtask

    task automatic lit(input string name, input int got, input int expv);
        lit_name  = name;
        lit_got   = got;
        lit_exp   = expv;
        lit_valid = 1'b1;
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] f7;
        logic [2:0] f3;
        int         nops, k, ab;

        chk_en = 1'b0; en_only = 1'b0; lit_valid = 1'b0; cur_name = "reset";
        rst = 1'b1;
        bus.op = '0; bus.func3 = '0; bus.func7 = '0; bus.Zero = 1'b0; bus.MemReady = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        build("add", OP_R, 3'd0, 7'h00, 0, 0, 0);        exec(-1); lit("add_cycles", dut_len, 4);
        build("lw_stall", OP_LW, 3'd2, 7'h00, 0, 2, 3);  exec(-1); lit("lw_stall_cycles", dut_len, 10);
        build("beq_z1", OP_B, 3'd0, 7'h00, 1, 0, 0);     exec(-1); lit("beq_cycles", dut_len, 3);
        build("beq_z0", OP_B, 3'd0, 7'h00, 0, 0, 0);     exec(-1);
        build("bne_z1", OP_B, 3'd1, 7'h00, 1, 0, 0);     exec(-1);
        build("bne_z0", OP_B, 3'd1, 7'h00, 0, 0, 0);     exec(-1);
        build("jalr", OP_JALR, 3'd0, 7'h00, 0, 0, 0);    exec(-1); lit("jalr_cycles", dut_len, 5);
        build("sw_stall", OP_SW, 3'd2, 7'h00, 0, 0, 2);  exec(-1); lit("sw_stall_cycles", dut_len, 6);
        build("lui", OP_LUI, 3'd0, 7'h00, 0, 0, 0);      exec(-1); lit("lui_cycles", dut_len, 3);
        build("jal", OP_JAL, 3'd0, 7'h00, 0, 0, 0);      exec(-1); lit("jal_cycles", dut_len, 4);
        build("sub", OP_R, 3'd0, 7'h20, 0, 0, 0);        exec(-1);
        build("slti", OP_I, 3'd2, 7'h00, 0, 1, 0);       exec(-1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        build("illegal_op", OP_BAD, 3'd0, 7'h00, 0, 0, 0); exec(-1);
        lit("illegal_flag", int'(bus.Illegal), 1);
        do_reset();
`else
        build("unknown_op", OP_BAD, 3'd0, 7'h00, 0, 0, 0); exec(-1); lit("nop_cycles", dut_len, 2);
`endif
        build("lw_abort", OP_LW, 3'd2, 7'h00, 0, 0, 1);  exec(3);

        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_BAD};
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        nops = 8;
`else
        nops = 9;
`endif
        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 2));
            f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
            f3 = 3'($urandom);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            if (ops[$urandom_range(0, nops - 1)] == OP_B) f3 = {2'b00, f3[0]};
`endif
            k = int'($urandom_range(0, nops - 1));
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            if (ops[k] == OP_B) f3 = {2'b00, f3[0]};
`endif
            build("random", ops[k], f3, f7, rb(),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, tr.size() - 1)) : -1;
            exec(ab);
        end

        build("final_lui", OP_LUI, 3'd0, 7'h00, 0, 0, 0); exec(-1);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
